// File: rtl/keypad_pkg.sv
// Shared types and key encoding for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Physical layout:
  //   r0: 1 2 3 A
  //   r1: 4 5 6 B
  //   r2: 7 8 9 C
  //   r3: * 0 # D
  function automatic logic [3:0] keymap(input logic [1:0] col_idx,
                                        input logic [1:0] row_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad rows.
// Resets to all ones so the idle (pulled-up) rows never look like a press.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 matrix keypad scanner: one active-low column at a time, rows sampled
// once per column dwell, debounced press/release, hex key code output.
//
// Outputs form a level interface: key_pressed is high while a debounced key
// is held and key_value holds the last accepted code (kept after release).
// key_strobe is a single-cycle pulse coincident with key_pressed rising.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_pressed,
  output logic [3:0] key_value,
  output logic       key_strobe
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  logic [3:0]       row_s;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       value_q, value_d;
  logic             pressed_q, pressed_d;
  logic             strobe_q, strobe_d;

  logic             tick;
  logic             any_low;
  logic [1:0]       row_idx;
  logic [3:0]       code;
  logic [CNT_W-1:0] cnt_inc;

  sync_2ff #(.W(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row_in),
    .q_o (row_s)
  );

  assign tick    = (div_q == DIV_LAST);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Row encoder: lowest low row in the active column wins.
  always_comb begin
    any_low = (row_s != 4'hF);
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) row_idx = r[1:0];
    end
    code = keymap(col_q, row_idx);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      div_q     <= '0;
      col_q     <= 2'd0;
      cnt_q     <= '0;
      cand_q    <= 4'h0;
      value_q   <= 4'h0;
      pressed_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      value_q   <= value_d;
      pressed_q <= pressed_d;
      strobe_q  <= strobe_d;
    end
  end

  // Next-state: dwell counter, column rotation and press/release debounce.
  // The column only advances from SCAN or when a debounce attempt fails or a
  // release completes; it is held throughout DEBOUNCE/PRESSED/RELEASE.
  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    col_d     = col_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    value_d   = value_q;
    pressed_d = pressed_q;
    strobe_d  = 1'b0;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            cand_d  = code;
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!any_low) begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end else if (code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_DONE) begin
              value_d   = cand_q;
              pressed_d = 1'b1;
              strobe_d  = 1'b1;
              state_d   = PRESSED;
            end
          end else begin
            cand_d = code;
            cnt_d  = CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!any_low) begin
            cnt_d   = CNT_W'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (any_low) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_DONE) begin
              pressed_d = 1'b0;
              cnt_d     = '0;
              col_d     = col_q + 2'd1;
              state_d   = SCAN;
            end
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  assign col_out     = ~(4'b0001 << col_q);
  assign key_pressed = pressed_q;
  assign key_value   = value_q;
  assign key_strobe  = strobe_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural keypad model.
module tb_keypad_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_pressed;
  logic [3:0] key_value;
  logic       key_strobe;

  // keys[row*4+col] = 1 while that key is physically held
  logic [15:0] keys = 16'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int strobe_bad = 0;
  logic pressed_prev = 1'b0;

  keypad_matrix_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_pressed (key_pressed),
    .key_value   (key_value),
    .key_strobe  (key_strobe)
  );

  // Clock
  always #5 clk = ~clk;

  // Keypad model: a held key pulls its row low only while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Strobe monitor: counts strobe cycles and flags any not aligned to a press edge.
  always @(negedge clk) begin
    if (key_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      if (!(key_pressed && !pressed_prev)) strobe_bad <= strobe_bad + 1;
    end
    pressed_prev <= key_pressed;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pressed(input logic val, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (key_pressed === val) ok = 1'b1;
    end
  endtask

  task automatic wait_col_change(input int max_cyc, output bit ok);
    logic [3:0] c0;
    c0 = col_out;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (col_out !== c0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4];
    exp_col[0] = 4'b1101;
    exp_col[1] = 4'b1011;
    exp_col[2] = 4'b0111;
    exp_col[3] = 4'b1110;
    rst  = 1'b1;
    keys = 16'h0;
    cycles(3);
    n_checks++;
    if (col_out !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b expected %b", col_out, 4'b1110); end
    n_checks++;
    if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed: got %b expected 0", key_pressed); end
    n_checks++;
    if (key_value !== 4'h0) begin n_fail++; $display("FAIL reset_value: got %h expected 0", key_value); end
    n_checks++;
    if (key_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", key_strobe); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycles(4);
      n_checks++;
      if (col_out !== exp_col[k]) begin
        n_fail++; $display("FAIL scan_rotate_%0d: got %b expected %b", k, col_out, exp_col[k]);
      end
    end
  endtask

  task automatic test_press_5();
    int s0;
    bit ok;
    s0 = strobe_cnt;
    keys[1*4+1] = 1'b1;
    wait_pressed(1'b1, 31, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL press5_timeout: key_pressed=%b expected 1 within 31 clks", key_pressed); end
    n_checks++;
    if (key_value !== 4'h5) begin n_fail++; $display("FAIL press5_value: got %h expected 5", key_value); end
    n_checks++;
    if (col_out !== 4'b1101) begin n_fail++; $display("FAIL press5_col: got %b expected 1101", col_out); end
    // 'A' sits in column 3, which is not driven while '5' is held
    keys[0*4+3] = 1'b1;
    cycles(20);
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL press5_strobes: got %0d expected 1", strobe_cnt - s0); end
    n_checks++;
    if (key_value !== 4'h5) begin n_fail++; $display("FAIL press5_with_A_value: got %h expected 5", key_value); end
    n_checks++;
    if (col_out !== 4'b1101) begin n_fail++; $display("FAIL press5_col_frozen: got %b expected 1101", col_out); end
    n_checks++;
    if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL press5_held: got %b expected 1", key_pressed); end
  endtask

  task automatic test_release_5();
    bit ok;
    keys = 16'h0;
    wait_pressed(1'b0, 40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL release5_timeout: key_pressed=%b expected 0 within 40 clks", key_pressed); end
    n_checks++;
    if (key_value !== 4'h5) begin n_fail++; $display("FAIL release5_value_kept: got %h expected 5", key_value); end
    wait_col_change(8, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL release5_scan_resume: col_out stuck at %b expected change", col_out); end
  endtask

  task automatic test_bounce_hash();
    int s0;
    bit ok;
    s0 = strobe_cnt;
    for (int i = 0; i < 8; i++) begin
      keys[3*4+2] = (i % 2 == 0);
      cycles(4);
    end
    keys[3*4+2] = 1'b1;
    wait_pressed(1'b1, 40, ok);
    cycles(8);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bounce_timeout: key_pressed=%b expected 1", key_pressed); end
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL bounce_strobes: got %0d expected 1", strobe_cnt - s0); end
    n_checks++;
    if (key_value !== 4'hF) begin n_fail++; $display("FAIL bounce_value: got %h expected f", key_value); end
    n_checks++;
    if (col_out !== 4'b1011) begin n_fail++; $display("FAIL bounce_col: got %b expected 1011", col_out); end
  endtask

  task automatic test_release_glitch();
    int s0;
    int drops;
    bit ok;
    s0 = strobe_cnt;
    drops = 0;
    keys[3*4+2] = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (key_pressed !== 1'b1) drops++; end
    keys[3*4+2] = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (key_pressed !== 1'b1) drops++; end
    keys[3*4+2] = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (key_pressed !== 1'b1) drops++; end
    n_checks++;
    if (drops !== 0) begin n_fail++; $display("FAIL glitch_pressed_held: %0d low cycles expected 0", drops); end
    n_checks++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", strobe_cnt - s0); end
    wait_pressed(1'b0, 40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hash_release_timeout: key_pressed=%b expected 0", key_pressed); end
    n_checks++;
    if (key_value !== 4'hF) begin n_fail++; $display("FAIL hash_release_value: got %h expected f", key_value); end
    wait_col_change(8, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hash_scan_resume: col_out stuck at %b expected change", col_out); end
  endtask

  task automatic test_multi_key();
    int s0;
    bit ok;
    s0 = strobe_cnt;
    keys[0*4+0] = 1'b1;
    keys[2*4+0] = 1'b1;
    wait_pressed(1'b1, 40, ok);
    cycles(4);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL multi_timeout: key_pressed=%b expected 1", key_pressed); end
    n_checks++;
    if (key_value !== 4'h1) begin n_fail++; $display("FAIL multi_value: got %h expected 1", key_value); end
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL multi_strobes: got %0d expected 1", strobe_cnt - s0); end
    keys = 16'h0;
    wait_pressed(1'b0, 40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL multi_release_timeout: key_pressed=%b expected 0", key_pressed); end
  endtask

  task automatic test_reset_in_debounce();
    int s0;
    rst  = 1'b1;
    keys = 16'h0;
    cycles(2);
    keys[1*4+1] = 1'b1;
    rst = 1'b0;
    // column 1 from edge 4, first sample at edge 8, cnt=2 after edge 12, press would land at edge 16
    cycles(13);
    n_checks++;
    if (col_out !== 4'b1101) begin n_fail++; $display("FAIL rstdeb_col_held: got %b expected 1101", col_out); end
    n_checks++;
    if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL rstdeb_not_yet: got %b expected 0", key_pressed); end
    s0 = strobe_cnt;
    rst = 1'b1;
    cycles(1);
    n_checks++;
    if (col_out !== 4'b1110) begin n_fail++; $display("FAIL rstdeb_col: got %b expected 1110", col_out); end
    n_checks++;
    if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL rstdeb_pressed: got %b expected 0", key_pressed); end
    n_checks++;
    if (key_value !== 4'h0) begin n_fail++; $display("FAIL rstdeb_value: got %h expected 0", key_value); end
    n_checks++;
    if (key_strobe !== 1'b0) begin n_fail++; $display("FAIL rstdeb_strobe: got %b expected 0", key_strobe); end
    cycles(3);
    keys = 16'h0;
    rst  = 1'b0;
    cycles(8);
    n_checks++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL rstdeb_no_strobe: got %0d expected 0", strobe_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_press_5();
    test_release_5();
    test_bounce_hash();
    test_release_glitch();
    test_multi_key();
    test_reset_in_debounce();
    cycles(2);
    n_checks++;
    if (strobe_bad !== 0) begin n_fail++; $display("FAIL strobe_alignment: %0d misaligned strobes expected 0", strobe_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
